// File: rtl/stats_window_controller_pkg.sv
// Shared definitions for the branch-statistics window sequencer.
// Holds the count width derivation (shared with the statistics counter
// block), the controller state encoding and the snapshot payload struct.
package stats_window_controller_pkg;

  localparam int unsigned TRAINING_DATA_SIZE     = 65536;
  localparam int unsigned INSTRUCTION_INDEX_SIZE = $clog2(TRAINING_DATA_SIZE);
  localparam int unsigned IDX                    = INSTRUCTION_INDEX_SIZE;

  typedef logic [IDX-1:0] count_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    WARMUP  = 3'd2,
    MEASURE = 3'd3,
    DRAIN   = 3'd4,
    REPORT  = 3'd5
  } state_e;

  typedef struct packed {
    count_t correct;
    count_t total;
    count_t mispredict;
  } snap_t;

endpackage

// File: rtl/stats_branch_counter.sv
// Count-to-limit branch counter with a terminal flag.
// Ports:
//   Clk, reset  : clock, async active-low reset
//   clr_i       : synchronous clear (wins over inc_i)
//   inc_i       : count one branch this cycle
//   limit_i     : number of branches that completes the run (must be != 0)
//   last_c_o    : combinational; this increment is the limit-th branch
module stats_branch_counter
  import stats_window_controller_pkg::*;
#(
  parameter int unsigned W = IDX
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic         last_c_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_c_o = inc_i && (count_q == (limit_i - W'(1)));

endmodule

// File: rtl/stats_window_controller.sv
// Measurement-campaign sequencer in front of the branch-statistics counter:
// clears the counter, skips a warm-up run of branches, gates counting for a
// window, then snapshots the counts and offers them over valid/ready.
// Ports:
//   Clk, reset                    : clock, async active-low reset
//   start_i, continuous_i, abort_i: campaign control
//   warmup_len_i, window_len_i    : lengths, latched on start
//   br_valid_i/predicted_i/actual_i: resolved branch stream
//   correct_in_i, total_in_i      : counts from the statistics counter
//   stat_enable_c_o, stat_result_c_o: combinational counter gate / outcome
//   stat_clear_n_o                : registered active-low clear pulse
//   snap_*                        : snapshot valid/ready + payload
//   busy_o                        : not idle
module stats_window_controller
  import stats_window_controller_pkg::*;
(
  input  logic           Clk,
  input  logic           reset,
  input  logic           start_i,
  input  logic           continuous_i,
  input  logic           abort_i,
  input  logic [IDX-1:0] warmup_len_i,
  input  logic [IDX-1:0] window_len_i,
  input  logic           br_valid_i,
  input  logic           br_predicted_i,
  input  logic           br_actual_i,
  input  logic [IDX-1:0] correct_in_i,
  input  logic [IDX-1:0] total_in_i,
  output logic           stat_enable_c_o,
  output logic           stat_result_c_o,
  output logic           stat_clear_n_o,
  output logic           snap_valid_o,
  input  logic           snap_ready_i,
  output logic [IDX-1:0] snap_correct_o,
  output logic [IDX-1:0] snap_total_o,
  output logic [IDX-1:0] snap_mispredict_o,
  output logic           busy_o
);

  state_e state_q, state_d;
  count_t warm_len_q, warm_len_d;
  count_t win_len_q, win_len_d;
  logic   cont_q, cont_d;
  snap_t  snap_q, snap_d;
  logic   snap_valid_q, snap_valid_d;
  logic   clear_n_q, clear_n_d;
  logic   busy_q, busy_d;

  logic   warm_inc, win_inc, cnt_clr;
  logic   warm_last, win_last;

  assign warm_inc = br_valid_i && (state_q == WARMUP);
  assign win_inc  = br_valid_i && (state_q == MEASURE);
  // Both run counters are held at zero outside an active campaign.
  assign cnt_clr  = abort_i || (state_q == IDLE) || (state_q == CLEAR);

  stats_branch_counter #(.W(IDX)) u_warm_cnt (
    .Clk      (Clk),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .inc_i    (warm_inc),
    .limit_i  (warm_len_q),
    .last_c_o (warm_last)
  );

  stats_branch_counter #(.W(IDX)) u_win_cnt (
    .Clk      (Clk),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .inc_i    (win_inc),
    .limit_i  (win_len_q),
    .last_c_o (win_last)
  );

  // Next-state, latched parameters, snapshot and registered output values.
  always_comb begin
    state_d    = state_q;
    warm_len_d = warm_len_q;
    win_len_d  = win_len_q;
    cont_d     = cont_q;
    snap_d     = snap_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          warm_len_d = warmup_len_i;
          win_len_d  = window_len_i;
          cont_d     = continuous_i;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        if (warm_len_q != '0) begin
          state_d = WARMUP;
        end else if (win_len_q != '0) begin
          state_d = MEASURE;
        end else begin
          state_d = DRAIN;
        end
      end
      WARMUP: begin
        // An empty window skips straight to the snapshot.
        if (warm_last) begin
          state_d = (win_len_q != '0) ? MEASURE : DRAIN;
        end
      end
      MEASURE: begin
        if (win_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        snap_d.correct    = correct_in_i;
        snap_d.total      = total_in_i;
        snap_d.mispredict = total_in_i - correct_in_i;
        state_d           = REPORT;
      end
      REPORT: begin
        if (snap_ready_i) begin
          state_d = cont_q ? CLEAR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_i) begin
      state_d = IDLE;
      snap_d  = '0;
    end

    snap_valid_d = (state_d == REPORT);
    clear_n_d    = (state_d != CLEAR);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      warm_len_q   <= '0;
      win_len_q    <= '0;
      cont_q       <= 1'b0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      clear_n_q    <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_len_q   <= warm_len_d;
      win_len_q    <= win_len_d;
      cont_q       <= cont_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      clear_n_q    <= clear_n_d;
      busy_q       <= busy_d;
    end
  end

  assign stat_enable_c_o   = win_inc;
  assign stat_result_c_o   = (br_predicted_i == br_actual_i);
  assign stat_clear_n_o    = clear_n_q;
  assign snap_valid_o      = snap_valid_q;
  assign snap_correct_o    = snap_q.correct;
  assign snap_total_o      = snap_q.total;
  assign snap_mispredict_o = snap_q.mispredict;
  assign busy_o            = busy_q;

endmodule

// File: tb/tb_stats_window_controller.sv
// Self-checking bench for stats_window_controller: directed scenarios plus
// randomized traffic, checked every cycle against a campaign-level model.
module tb_stats_window_controller;
  import stats_window_controller_pkg::*;

  localparam int unsigned W = IDX;

  logic         Clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0, continuous = 1'b0, abort = 1'b0;
  logic [W-1:0] warmup_len = '0, window_len = '0;
  logic         br_valid = 1'b0, br_predicted = 1'b0, br_actual = 1'b0;
  logic [W-1:0] cnt_correct, cnt_total;
  logic         stat_enable, stat_result, stat_clear_n;
  logic         snap_valid;
  logic         snap_ready = 1'b0;
  logic [W-1:0] snap_correct, snap_total, snap_mispredict;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  stats_window_controller dut (
    .Clk              (Clk),
    .reset            (reset),
    .start_i          (start),
    .continuous_i     (continuous),
    .abort_i          (abort),
    .warmup_len_i     (warmup_len),
    .window_len_i     (window_len),
    .br_valid_i       (br_valid),
    .br_predicted_i   (br_predicted),
    .br_actual_i      (br_actual),
    .correct_in_i     (cnt_correct),
    .total_in_i       (cnt_total),
    .stat_enable_c_o  (stat_enable),
    .stat_result_c_o  (stat_result),
    .stat_clear_n_o   (stat_clear_n),
    .snap_valid_o     (snap_valid),
    .snap_ready_i     (snap_ready),
    .snap_correct_o   (snap_correct),
    .snap_total_o     (snap_total),
    .snap_mispredict_o(snap_mispredict),
    .busy_o           (busy)
  );

  // Stand-in for the statistics counter block driven by the DUT.
  always @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cnt_correct <= '0;
      cnt_total   <= '0;
    end else if (!stat_clear_n) begin
      cnt_correct <= '0;
      cnt_total   <= '0;
    end else if (stat_enable) begin
      cnt_total <= cnt_total + W'(1);
      if (stat_result) cnt_correct <= cnt_correct + W'(1);
    end
  end

  function automatic void check(string nm, longint got, longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endfunction

  // Campaign-level model: what the controller is doing this cycle, how many
  // branches remain to skip / count, and the outcome tally of the window.
  localparam int PH_IDLE = 0, PH_CLR = 1, PH_SKIP = 2, PH_CNT = 3, PH_DRN = 4, PH_REP = 5;
  int           m_phase;
  int           m_warm, m_win, m_skip, m_left, m_acc_c, m_acc_t;
  bit           m_cont;
  logic [W-1:0] m_snap_c, m_snap_t;

  function automatic void model_reset();
    m_phase = PH_IDLE; m_warm = 0; m_win = 0; m_skip = 0; m_left = 0;
    m_acc_c = 0; m_acc_t = 0; m_cont = 1'b0; m_snap_c = '0; m_snap_t = '0;
  endfunction

  function automatic int after_skip(int left);
    return (left > 0) ? PH_CNT : PH_DRN;
  endfunction

  function automatic void model_step();
    if (!reset) begin
      model_reset();
      return;
    end
    if (abort) begin
      m_phase = PH_IDLE;
      return;
    end
    case (m_phase)
      PH_IDLE: if (start) begin
        m_warm = int'(warmup_len); m_win = int'(window_len); m_cont = continuous;
        m_phase = PH_CLR;
      end
      PH_CLR: begin
        m_skip = m_warm; m_left = m_win; m_acc_c = 0; m_acc_t = 0;
        m_phase = (m_skip > 0) ? PH_SKIP : after_skip(m_left);
      end
      PH_SKIP: if (br_valid) begin
        m_skip--;
        if (m_skip == 0) m_phase = after_skip(m_left);
      end
      PH_CNT: if (br_valid) begin
        m_acc_t++;
        if (br_predicted == br_actual) m_acc_c++;
        m_left--;
        if (m_left == 0) m_phase = PH_DRN;
      end
      PH_DRN: begin
        m_snap_c = W'(m_acc_c); m_snap_t = W'(m_acc_t);
        m_phase = PH_REP;
      end
      PH_REP: if (snap_ready) m_phase = m_cont ? PH_CLR : PH_IDLE;
      default: m_phase = PH_IDLE;
    endcase
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    logic [W-1:0] exp_mis;
    check("busy", busy, m_phase != PH_IDLE);
    check("snap_valid", snap_valid, m_phase == PH_REP);
    check("stat_clear_n", stat_clear_n, m_phase != PH_CLR);
    check("stat_enable", stat_enable, br_valid && (m_phase == PH_CNT));
    check("stat_result", stat_result, br_predicted == br_actual);
    if (m_phase == PH_REP) begin
      exp_mis = m_snap_t - m_snap_c;
      check("snap_correct", snap_correct, m_snap_c);
      check("snap_total", snap_total, m_snap_t);
      check("snap_mispredict", snap_mispredict, exp_mis);
    end
  end

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_valid(int budget);
    int n = 0;
    while (!snap_valid && n < budget) begin
      tick();
      n++;
    end
    if (!snap_valid) check("wait_snap_valid_timeout", 0, 1);
  endtask

  task automatic launch(int wl, int nl, bit cont);
    warmup_len = W'(wl); window_len = W'(nl); continuous = cont; start = 1'b1;
    tick();
  endtask

  task automatic branch(bit p, bit a);
    br_valid = 1'b1; br_predicted = p; br_actual = a;
    tick();
  endtask

  task automatic handshake();
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rep, n_clr, bp_c, bp_t;
    model_reset();
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_snap_valid", snap_valid, 0);
    check("reset_clear_n", stat_clear_n, 1);
    check("reset_snap_total", snap_total, 0);
    reset = 1'b1;
    tick();

    // Basic window: 2 warm-up + 4 counted branches (C, W, C, C).
    launch(2, 4, 0);
    check("basic_clear_pulse", stat_clear_n, 0);
    br_valid = 1'b0;
    tick();
    branch(1, 1); branch(0, 1);
    branch(1, 1); branch(1, 0); branch(0, 0); branch(1, 1);
    br_valid = 1'b0;
    check("basic_drain_no_valid", snap_valid, 0);
    tick();
    check("basic_valid_lat2", snap_valid, 1);
    check("basic_correct", snap_correct, 3);
    check("basic_total", snap_total, 4);
    check("basic_mispredict", snap_mispredict, 1);
    handshake();
    check("basic_valid_drop", snap_valid, 0);
    check("basic_idle", busy, 0);

    // Zero lengths: CLEAR, DRAIN, REPORT with 0/0/0.
    launch(0, 0, 0);
    br_valid = 1'b1; br_predicted = 1'b1; br_actual = 1'b1;
    tick();
    tick();
    check("zero_valid", snap_valid, 1);
    check("zero_total", snap_total, 0);
    check("zero_correct", snap_correct, 0);
    check("zero_mispredict", snap_mispredict, 0);
    handshake();
    br_valid = 1'b0;

    // Backpressure: snapshot held for 10 cycles while branches keep coming.
    launch(0, 3, 0);
    br_valid = 1'b0;
    tick();
    branch(1, 1); branch(0, 1); branch(0, 0);
    br_valid = 1'b0;
    wait_valid(5);
    bp_c = int'(snap_correct); bp_t = int'(snap_total);
    check("bp_correct", bp_c, 2);
    check("bp_total", bp_t, 3);
    for (int i = 0; i < 10; i++) begin
      br_valid = ~br_valid; br_predicted = 1'($urandom); br_actual = 1'($urandom);
      tick();
      check("bp_hold_total", snap_total, bp_t);
      check("bp_counter_frozen", cnt_total, 3);
    end
    br_valid = 1'b0;
    handshake();
    check("bp_valid_drop", snap_valid, 0);

    // Continuous: every window reports 3/3/0, one clear pulse per window.
    launch(1, 3, 1);
    snap_ready = 1'b1;
    br_valid = 1'b1; br_predicted = 1'b1; br_actual = 1'b1;
    n_rep = 0; n_clr = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!stat_clear_n) n_clr++;
      if (snap_valid) begin
        n_rep++;
        check("cont_correct", snap_correct, 3);
        check("cont_mispredict", snap_mispredict, 0);
      end
    end
    check("cont_reports", n_rep, 5);
    check("cont_clears", n_clr, 5);
    abort = 1'b1; br_valid = 1'b0; snap_ready = 1'b0;
    tick();
    check("cont_abort_idle", busy, 0);

    // Abort in MEASURE after 2 of 5 branches, then a fresh campaign.
    launch(0, 5, 0);
    br_valid = 1'b0;
    tick();
    branch(1, 1); branch(1, 1);
    br_valid = 1'b0; abort = 1'b1;
    tick();
    check("abort_idle", busy, 0);
    n_rep = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (snap_valid) n_rep++;
    end
    check("abort_no_valid", n_rep, 0);
    launch(0, 5, 0);
    check("abort_fresh_clear", stat_clear_n, 0);
    br_valid = 1'b0;
    tick();
    branch(1, 1); branch(1, 0); branch(0, 0); branch(0, 1); branch(1, 1);
    br_valid = 1'b0;
    wait_valid(5);
    check("abort_new_correct", snap_correct, 3);
    check("abort_new_total", snap_total, 5);
    check("abort_new_mispredict", snap_mispredict, 2);
    handshake();

    // Async reset mid-WARMUP, between clock edges.
    launch(10, 2, 0);
    br_valid = 1'b0;
    tick();
    branch(1, 1); branch(1, 1); branch(1, 1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("areset_busy", busy, 0);
    check("areset_snap_valid", snap_valid, 0);
    check("areset_clear_n", stat_clear_n, 1);
    check("areset_enable", stat_enable, 0);
    check("areset_snap_total", snap_total, 0);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      tick();
      check("areset_start_ignored", busy, 0);
    end
    br_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Maximum window: 2^IDX-1 branches, alternating correct/wrong.
    launch(0, (1 << W) - 1, 0);
    br_valid = 1'b0;
    tick();
    for (int i = 0; i < (1 << W) - 1; i++) branch(1'b1, (i % 2) == 0);
    br_valid = 1'b0;
    wait_valid(5);
    check("max_total", snap_total, 65535);
    check("max_correct", snap_correct, 32768);
    check("max_mispredict", snap_mispredict, 32767);
    handshake();

    // Randomized traffic, including stray starts and occasional aborts.
    for (int i = 0; i < 2000; i++) begin
      start        = ($urandom_range(0, 7) == 0);
      continuous   = 1'($urandom);
      warmup_len   = W'($urandom_range(0, 4));
      window_len   = W'($urandom_range(0, 6));
      br_valid     = ($urandom_range(0, 9) < 7);
      br_predicted = 1'($urandom);
      br_actual    = 1'($urandom);
      snap_ready   = 1'($urandom);
      abort        = ($urandom_range(0, 63) == 0);
      tick();
    end
    abort = 1'b1; br_valid = 1'b0; snap_ready = 1'b0;
    tick();
    check("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
